// File: rtl/apb_qch_ctrl.sv
// ---------------------------------------------------------------------------------------------
// apb_qch_ctrl
//
// Q-channel quiescence controller for the always-on side of an APB isolator. Requests
// quiescence on a software stop or after a programmable run of idle cycles, sequences the
// gated domain's power switch, and wakes the domain on APB activity, wake_i or software
// release. The domain boots to RUN on its own: the reset state EXIT matches the isolator,
// which holds qacceptn low during its own reset.
//
// Optional feature macro: QCH_TIMEOUT_EN
//   defined   - sticky timeout_o flags a Q-channel handshake stuck in REQ or EXIT for TO_CYC
//               cycles; to_clr_i clears it (a new timeout in the same cycle wins)
//   undefined - timeout_o is constant 0, to_clr_i is ignored, no counter is built
//
// Ports
//   pclk_i       in   clock
//   presetn_i    in   asynchronous active-low reset
//   sw_stop_i    in   level, 1 = software demands the domain stopped
//   auto_en_i    in   1 = idle-timer auto stop enabled
//   idle_thr_i   in   idle cycles required before auto stop
//   wake_i       in   level wake request from always-on logic
//   to_clr_i     in   pulse, clears timeout_o
//   qreqn_o      out  Q-channel request (0 = request quiescence)
//   qacceptn_i   in   Q-channel accept from the isolator
//   qdeny_i      in   Q-channel deny from the isolator
//   qactive_i    in   activity hint from the isolator
//   pwr_off_o    out  1 = switch off gated domain power
//   stopped_o    out  1 = state STOPPED
//   state_o      out  STOPPED=0 PWRUP=1 EXIT=2 RUN=3 REQ=4 DENIED=5
//   timeout_o    out  sticky handshake-timeout flag
// ---------------------------------------------------------------------------------------------
module apb_qch_ctrl #(
    parameter int unsigned IDLE_W  = 8,
    parameter int unsigned PWR_DLY = 4,
    parameter int unsigned TO_CYC  = 64
) (
    input  logic              pclk_i,
    input  logic              presetn_i,
    input  logic              sw_stop_i,
    input  logic              auto_en_i,
    input  logic [IDLE_W-1:0] idle_thr_i,
    input  logic              wake_i,
    input  logic              to_clr_i,
    output logic              qreqn_o,
    input  logic              qacceptn_i,
    input  logic              qdeny_i,
    input  logic              qactive_i,
    output logic              pwr_off_o,
    output logic              stopped_o,
    output logic [2:0]        state_o,
    output logic              timeout_o
);

    localparam int unsigned     DLY_W    = (PWR_DLY < 2) ? 1 : $clog2(PWR_DLY + 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(PWR_DLY - 1);

    typedef enum logic [2:0] {
        StStopped = 3'd0,
        StPwrup   = 3'd1,
        StExit    = 3'd2,
        StRun     = 3'd3,
        StReq     = 3'd4,
        StDenied  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [DLY_W-1:0]    dly_cnt_q, dly_cnt_d;
    logic                qreqn_q, qreqn_d;
    logic                pwr_off_q, pwr_off_d;
    logic                stopped_q, stopped_d;
    logic                stop_req, exit_req;

    assign stop_req = sw_stop_i | (auto_en_i & ~qactive_i & (idle_cnt_q >= idle_thr_i));
    assign exit_req = ~sw_stop_i & (wake_i | qactive_i | ~auto_en_i);

    // Next-state, delay counter and power-switch decode
    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        pwr_off_d = 1'b0;
        case (state_q)
            StExit: begin
                if (qacceptn_i) state_d = StRun;
            end
            StRun: begin
                if (stop_req) state_d = StReq;
            end
            StReq: begin
                // Accept wins over a simultaneous deny; the request is never withdrawn.
                if (!qacceptn_i) begin
                    state_d   = StStopped;
                    dly_cnt_d = '0;
                end else if (qdeny_i) begin
                    state_d = StDenied;
                end
            end
            StDenied: begin
                if (!qdeny_i) state_d = StRun;
            end
            StStopped: begin
                pwr_off_d = pwr_off_q;
                if (exit_req) begin
                    // Power still on: skip the power-up wait and go straight to EXIT.
                    state_d   = pwr_off_q ? StPwrup : StExit;
                    dly_cnt_d = '0;
                    pwr_off_d = 1'b0;
                end else if (!pwr_off_q) begin
                    dly_cnt_d = dly_cnt_q + DLY_W'(1);
                    if (dly_cnt_q == DLY_LAST) pwr_off_d = 1'b1;
                end
            end
            StPwrup: begin
                if (dly_cnt_q == DLY_LAST) begin
                    state_d   = StExit;
                    dly_cnt_d = '0;
                end else begin
                    dly_cnt_d = dly_cnt_q + DLY_W'(1);
                end
            end
            default: begin
                state_d   = StExit;
                dly_cnt_d = '0;
            end
        endcase
    end

    // Request is held low from REQ until the domain is back in EXIT.
    always_comb begin
        qreqn_d   = ~((state_d == StReq) || (state_d == StStopped) || (state_d == StPwrup));
        stopped_d = (state_d == StStopped);
    end

    // Saturating idle counter, only live while running with auto stop enabled
    always_comb begin
        if (qactive_i || !auto_en_i || (state_q != StRun)) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == {IDLE_W{1'b1}}) begin
            idle_cnt_d = idle_cnt_q;
        end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q    <= StExit;
            qreqn_q    <= 1'b1;
            pwr_off_q  <= 1'b0;
            stopped_q  <= 1'b0;
            idle_cnt_q <= '0;
            dly_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            qreqn_q    <= qreqn_d;
            pwr_off_q  <= pwr_off_d;
            stopped_q  <= stopped_d;
            idle_cnt_q <= idle_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
        end
    end

    assign qreqn_o   = qreqn_q;
    assign pwr_off_o = pwr_off_q;
    assign stopped_o = stopped_q;
    assign state_o   = state_q;

`ifdef QCH_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TO_CYC + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
    logic            to_wait, to_hit;

    assign to_wait = (state_q == StReq) || (state_q == StExit);
    assign to_hit  = to_wait && (to_cnt_q == TO_W'(TO_CYC - 1));

    // Counter saturates at TO_CYC so a cleared flag is not re-set by the same stuck handshake.
    always_comb begin
        to_cnt_d = '0;
        if (to_wait) begin
            to_cnt_d = (to_cnt_q == TO_W'(TO_CYC)) ? to_cnt_q : to_cnt_q + TO_W'(1);
        end
        timeout_d = timeout_q;
        if (to_clr_i) timeout_d = 1'b0;
        if (to_hit)   timeout_d = 1'b1;
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_to;
    assign unused_to = to_clr_i | (TO_CYC == 32'd0);
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_qch_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_apb_qch_ctrl
//
// Directed bench for apb_qch_ctrl with IDLE_W=8, PWR_DLY=4, TO_CYC=16. The isolator side of
// the Q-channel is driven by hand. Inputs change 1 time unit after the rising edge and the
// outputs are sampled at that point.
// ---------------------------------------------------------------------------------------------
module tb_apb_qch_ctrl;

    localparam int unsigned IDLE_W  = 8;
    localparam int unsigned PWR_DLY = 4;
    localparam int unsigned TO_CYC  = 16;

    localparam int ST_STOPPED = 0;
    localparam int ST_PWRUP   = 1;
    localparam int ST_EXIT    = 2;
    localparam int ST_RUN     = 3;
    localparam int ST_REQ     = 4;
    localparam int ST_DENIED  = 5;

    logic              pclk = 1'b0;
    logic              presetn;
    logic              sw_stop;
    logic              auto_en;
    logic [IDLE_W-1:0] idle_thr;
    logic              wake;
    logic              to_clr;
    logic              qreqn;
    logic              qacceptn;
    logic              qdeny;
    logic              qactive;
    logic              pwr_off;
    logic              stopped;
    logic [2:0]        state;
    logic              timeout;

    int n_checks = 0;
    int n_fail   = 0;

    apb_qch_ctrl #(
        .IDLE_W  (IDLE_W),
        .PWR_DLY (PWR_DLY),
        .TO_CYC  (TO_CYC)
    ) u_dut (
        .pclk_i     (pclk),
        .presetn_i  (presetn),
        .sw_stop_i  (sw_stop),
        .auto_en_i  (auto_en),
        .idle_thr_i (idle_thr),
        .wake_i     (wake),
        .to_clr_i   (to_clr),
        .qreqn_o    (qreqn),
        .qacceptn_i (qacceptn),
        .qdeny_i    (qdeny),
        .qactive_i  (qactive),
        .pwr_off_o  (pwr_off),
        .stopped_o  (stopped),
        .state_o    (state),
        .timeout_o  (timeout)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_fsm(input string tag, input int st, input int exp_qreqn,
                             input int exp_pwr_off);
        check_eq({tag, ".state"}, 32'(state), st);
        check_eq({tag, ".qreqn"}, 32'(qreqn), exp_qreqn);
        check_eq({tag, ".pwr_off"}, 32'(pwr_off), exp_pwr_off);
        check_eq({tag, ".stopped"}, 32'(stopped), (st == ST_STOPPED) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        presetn  = 1'b0;
        sw_stop  = 1'b0;
        auto_en  = 1'b0;
        idle_thr = 8'd8;
        wake     = 1'b0;
        to_clr   = 1'b0;
        qacceptn = 1'b0;
        qdeny    = 1'b0;
        qactive  = 1'b0;
        repeat (3) tick();
        check_fsm("reset", ST_EXIT, 1, 0);
        check_eq("reset.timeout", 32'(timeout), 0);

        // 1: boot, isolator holds accept low one cycle then raises it
        presetn = 1'b1;
        tick();
        check_fsm("t1_exit_hold", ST_EXIT, 1, 0);
        qacceptn = 1'b1;
        tick();
        check_fsm("t1_run", ST_RUN, 1, 0);

        // 2: idle auto stop, activity pulse after 5 cycles restarts the count
        auto_en = 1'b1;
        repeat (5) tick();
        check_fsm("t2_pre_pulse", ST_RUN, 1, 0);
        qactive = 1'b1;
        tick();
        qactive = 1'b0;
        repeat (8) tick();
        check_fsm("t2_restart", ST_RUN, 1, 0);
        tick();
        check_fsm("t2_req", ST_REQ, 0, 0);

        // 3: accept, power-off delay, wake on activity through PWRUP
        qacceptn = 1'b0;
        tick();
        check_fsm("t3_stopped", ST_STOPPED, 0, 0);
        repeat (3) tick();
        check_fsm("t3_dly3", ST_STOPPED, 0, 0);
        tick();
        check_fsm("t3_pwr_off", ST_STOPPED, 0, 1);
        repeat (2) tick();
        qactive = 1'b1;
        tick();
        qactive = 1'b0;
        check_fsm("t3_pwrup", ST_PWRUP, 0, 0);
        repeat (3) tick();
        check_fsm("t3_pwrup_hold", ST_PWRUP, 0, 0);
        tick();
        check_fsm("t3_exit", ST_EXIT, 1, 0);
        tick();
        check_fsm("t3_exit_wait", ST_EXIT, 1, 0);
        qacceptn = 1'b1;
        tick();
        check_fsm("t3_run", ST_RUN, 1, 0);

        // 4: deny path
        auto_en = 1'b0;
        sw_stop = 1'b1;
        tick();
        sw_stop = 1'b0;
        check_fsm("t4_req", ST_REQ, 0, 0);
        qdeny = 1'b1;
        tick();
        check_fsm("t4_denied", ST_DENIED, 1, 0);
        tick();
        check_fsm("t4_denied_hold", ST_DENIED, 1, 0);
        qdeny = 1'b0;
        tick();
        check_fsm("t4_run", ST_RUN, 1, 0);

        // accept and deny together: accept wins
        sw_stop = 1'b1;
        tick();
        check_fsm("both_req", ST_REQ, 0, 0);
        qacceptn = 1'b0;
        qdeny    = 1'b1;
        tick();
        qdeny = 1'b0;
        check_fsm("both_stopped", ST_STOPPED, 0, 0);

        // 5: sw_stop held blocks wake and activity
        wake = 1'b1;
        tick();
        wake    = 1'b0;
        qactive = 1'b1;
        tick();
        qactive = 1'b0;
        check_fsm("t5_blocked", ST_STOPPED, 0, 0);
        repeat (2) tick();
        check_fsm("t5_pwr_off", ST_STOPPED, 0, 1);
        wake    = 1'b1;
        qactive = 1'b1;
        tick();
        wake    = 1'b0;
        qactive = 1'b0;
        check_fsm("t5_still_blocked", ST_STOPPED, 0, 1);
        sw_stop = 1'b0;
        tick();
        check_fsm("t5_pwrup", ST_PWRUP, 0, 0);
        // stop request raised mid power-up does not abort the wake
        sw_stop = 1'b1;
        repeat (3) tick();
        check_fsm("t5_pwrup_hold", ST_PWRUP, 0, 0);
        tick();
        check_fsm("t5_exit", ST_EXIT, 1, 0);
        qacceptn = 1'b1;
        tick();
        check_fsm("t5_run", ST_RUN, 1, 0);
        tick();
        check_fsm("t5_rereq", ST_REQ, 0, 0);

        // 6: handshake stuck in REQ (accept high, no deny)
`ifdef QCH_TIMEOUT_EN
        repeat (15) tick();
        check_eq("t6_before_to", 32'(timeout), 0);
        tick();
        check_eq("t6_timeout", 32'(timeout), 1);
        check_fsm("t6_still_req", ST_REQ, 0, 0);
        tick();
        check_eq("t6_sticky", 32'(timeout), 1);
        to_clr = 1'b1;
        tick();
        to_clr = 1'b0;
        check_eq("t6_cleared", 32'(timeout), 0);
        tick();
        check_eq("t6_stays_clear", 32'(timeout), 0);
`else
        repeat (20) tick();
        check_eq("t6_no_timeout", 32'(timeout), 0);
        check_fsm("t6_still_req", ST_REQ, 0, 0);
        to_clr = 1'b1;
        tick();
        to_clr = 1'b0;
        check_eq("t6_clr_ignored", 32'(timeout), 0);
`endif

        // exit request in the same cycle the power-off delay expires: exit wins
        sw_stop  = 1'b0;
        auto_en  = 1'b1;
        qacceptn = 1'b0;
        tick();
        check_fsm("race_stopped", ST_STOPPED, 0, 0);
        repeat (3) tick();
        check_fsm("race_dly3", ST_STOPPED, 0, 0);
        wake = 1'b1;
        tick();
        wake = 1'b0;
        check_fsm("race_exit", ST_EXIT, 1, 0);
        qacceptn = 1'b1;
        tick();
        check_fsm("race_run", ST_RUN, 1, 0);

        // reset while powered off
        sw_stop = 1'b1;
        tick();
        qacceptn = 1'b0;
        tick();
        check_fsm("rst_stopped", ST_STOPPED, 0, 0);
        repeat (4) tick();
        check_fsm("rst_pwr_off", ST_STOPPED, 0, 1);
        presetn = 1'b0;
        #1;
        check_fsm("rst_mid", ST_EXIT, 1, 0);
        check_eq("rst_mid.timeout", 32'(timeout), 0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
